// File: rtl/disk_controller.sv
// Block-transfer controller: moves 128-word blocks between a host-visible buffer and word-addressed storage.
// Optional mem_ack timeout watchdog is enabled by defining DISK_CTRL_TIMEOUT_EN.
module disk_controller #(
    parameter int BLOCK_BITS     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic [31:0]             instruction,
    input  logic                    write_pause,
    input  logic                    read_pause,
    input  logic [8:0]              disk_addr,
    input  logic [31:0]             host_wdata,
    output logic [31:0]             host_rdata,
    output logic                    disk_operate_done,
    output logic                    disk_busy,
    output logic                    disk_error,
    output logic [BLOCK_BITS+6:0]   mem_addr,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ack
);

    // Storage handshake: mem_req is held until a mem_ack arrives in the same cycle;
    // the word transfers on that edge, and a mem_ack while mem_req is low is ignored.
    typedef enum logic [2:0] {IDLE, RD_REQ, WR_LOAD, WR_REQ, DONE} state_t;

    state_t                  state;
    logic [BLOCK_BITS-1:0]   block;
    logic [6:0]              index;
    logic [31:0]             buffer [128];

    logic ack;
    logic last_word;
    logic host_we;
    logic timeout;

    assign ack       = mem_req & mem_ack;
    assign last_word = (index == 7'd127);
    assign host_we   = cs & instruction[31] & ~instruction[30] & ~disk_busy;

    assign host_rdata = buffer[disk_addr[8:2]];
    assign mem_addr   = {block, index};

    // Buffer contents survive reset, so this array sits outside the reset domain.
    always_ff @(posedge clk) begin
        if (state == RD_REQ && ack)
            buffer[index] <= mem_rdata;
        else if (host_we)
            buffer[disk_addr[8:2]] <= host_wdata;
    end

`ifdef DISK_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          unused_bits;

    assign timeout     = mem_req & ~mem_ack & (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign unused_bits = ^{instruction[29:BLOCK_BITS], disk_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (!mem_req || mem_ack || timeout)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    // The error flag is sticky until the host starts a new transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            disk_error <= 1'b0;
        else if (timeout)
            disk_error <= 1'b1;
        else if (state == IDLE && (read_pause || write_pause))
            disk_error <= 1'b0;
    end
`else
    logic unused_bits;

    assign timeout     = 1'b0;
    assign disk_error  = 1'b0;
    assign unused_bits = ^{instruction[29:BLOCK_BITS], disk_addr[1:0], TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            index             <= 7'd0;
            block             <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_wdata         <= 32'd0;
            disk_operate_done <= 1'b0;
            disk_busy         <= 1'b0;
        end else begin
            disk_operate_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_pause) begin
                        block     <= instruction[BLOCK_BITS-1:0];
                        index     <= 7'd0;
                        disk_busy <= 1'b1;
                        state     <= WR_LOAD;
                    end else if (read_pause) begin
                        block     <= instruction[BLOCK_BITS-1:0];
                        index     <= 7'd0;
                        disk_busy <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (timeout) begin
                        mem_req           <= 1'b0;
                        disk_operate_done <= 1'b1;
                        state             <= DONE;
                    end else if (ack) begin
                        if (last_word) begin
                            mem_req           <= 1'b0;
                            disk_operate_done <= 1'b1;
                            state             <= DONE;
                        end else begin
                            index <= index + 7'd1;
                        end
                    end
                end
                WR_LOAD: begin
                    mem_wdata <= buffer[index];
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    state     <= WR_REQ;
                end
                WR_REQ: begin
                    if (timeout) begin
                        mem_req           <= 1'b0;
                        mem_we            <= 1'b0;
                        disk_operate_done <= 1'b1;
                        state             <= DONE;
                    end else if (ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (last_word) begin
                            disk_operate_done <= 1'b1;
                            state             <= DONE;
                        end else begin
                            index <= index + 7'd1;
                            state <= WR_LOAD;
                        end
                    end
                end
                DONE: begin
                    disk_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    disk_busy <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disk_controller.sv
// Self-checking bench for disk_controller: zero-wait storage model returning data = address,
// scoreboard queues for storage reads and writes, one task per scenario.
module tb_disk_controller;

    localparam int BB  = 16;
    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [31:0] instruction;
    logic        write_pause;
    logic        read_pause;
    logic [8:0]  disk_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        disk_operate_done;
    logic        disk_busy;
    logic        disk_error;
    logic [BB+6:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic ack_en;
    logic ack_force;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    logic [22:0] rd_q[$];
    logic [54:0] wr_q[$];

    disk_controller #(.BLOCK_BITS(BB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cs(cs), .instruction(instruction),
        .write_pause(write_pause), .read_pause(read_pause),
        .disk_addr(disk_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .disk_operate_done(disk_operate_done), .disk_busy(disk_busy), .disk_error(disk_error),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_ack   = (mem_req & ack_en) | ack_force;
    assign mem_rdata = {9'd0, mem_addr};

    // Storage-side scoreboard: every acknowledged access pops the oldest expected entry.
    always @(negedge clk) begin
        if (disk_operate_done) done_cnt++;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                n_total++;
                if (wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected: addr=%h data=%h, expected no write", mem_addr, mem_wdata);
                end else begin
                    logic [54:0] e;
                    e = wr_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e)
                        $display("FAIL wr_access: addr/data=%h/%h, expected %h/%h", mem_addr, mem_wdata, e[54:32], e[31:0]);
                    else
                        n_pass++;
                end
            end else begin
                n_total++;
                if (rd_q.size() == 0) begin
                    $display("FAIL rd_unexpected: addr=%h, expected no read", mem_addr);
                end else begin
                    logic [22:0] e;
                    e = rd_q.pop_front();
                    if (mem_addr !== e)
                        $display("FAIL rd_addr: addr=%h, expected %h", mem_addr, e);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pause(input bit wr, input logic [15:0] blk);
        next_cycle();
        instruction = {1'b0, 1'b1, 14'd0, blk};
        write_pause = wr;
        read_pause  = ~wr;
        next_cycle();
        write_pause = 1'b0;
        read_pause  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (disk_operate_done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic push_reads(input logic [15:0] blk);
        for (int i = 0; i < 128; i++) rd_q.push_back({blk, 7'(i)});
    endtask

    task automatic check_queues_and_done(input string name, input int exp_done);
        repeat (3) @(negedge clk);
        n_total++;
        if (done_cnt !== exp_done)
            $display("FAIL %s_done_count: got %0d, expected %0d", name, done_cnt, exp_done);
        else
            n_pass++;
        n_total++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL %s_queue_left: rd=%0d wr=%0d, expected 0/0", name, rd_q.size(), wr_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, disk_operate_done, disk_busy, disk_error} !== 5'b0 || mem_wdata !== 32'd0 || mem_addr !== 23'd0)
            $display("FAIL reset_outputs: req/we/done/busy/err=%b wdata=%h addr=%h, expected all 0",
                     {mem_req, mem_we, disk_operate_done, disk_busy, disk_error}, mem_wdata, mem_addr);
        else
            n_pass++;
        rst = 1'b0;
        next_cycle();
        ack_force = 1'b1;
        next_cycle();
        ack_force = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_req, disk_busy, disk_operate_done} !== 3'b000 || done_cnt != 0)
            $display("FAIL idle_stray_ack: req/busy/done=%b, expected 000", {mem_req, disk_busy, disk_operate_done});
        else
            n_pass++;
    endtask

    task automatic test_host_write();
        logic [31:0] d;
        d = $urandom;
        next_cycle();
        cs = 1'b1; instruction = 32'h8000_0000; disk_addr = 9'h008; host_wdata = 32'hDEAD_BEEF;
        next_cycle();
        disk_addr = 9'h1FC; host_wdata = d;
        next_cycle();
        cs = 1'b0;
        n_total++;
        if (host_rdata !== d) $display("FAIL host_write_1fc: got %h, expected %h", host_rdata, d);
        else n_pass++;
        disk_addr = 9'h008;
        #1;
        n_total++;
        if (host_rdata !== 32'hDEAD_BEEF) $display("FAIL host_write_008: got %h, expected deadbeef", host_rdata);
        else n_pass++;
    endtask

    task automatic test_read();
        int cyc;
        done_cnt = 0;
        push_reads(16'h0003);
        start_pause(1'b0, 16'h0003);
        n_total++;
        if ({disk_busy, mem_req, mem_we} !== 3'b110 || mem_addr !== 23'h180)
            $display("FAIL read_start: busy/req/we=%b addr=%h, expected 110 / 180", {disk_busy, mem_req, mem_we}, mem_addr);
        else
            n_pass++;
        wait_done(cyc);
        n_total++;
        if (cyc != 129) $display("FAIL read_latency: done at cycle %0d, expected 129", cyc);
        else n_pass++;
        check_queues_and_done("read", 1);
        n_total++;
        if (disk_busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL read_idle: busy/req=%b%b, expected 00", disk_busy, mem_req);
        else n_pass++;
        disk_addr = 9'h014;
        #1;
        n_total++;
        if (host_rdata !== 32'h185) $display("FAIL read_buf5: got %h, expected 185", host_rdata);
        else n_pass++;
        disk_addr = 9'h1FC;
        #1;
        n_total++;
        if (host_rdata !== 32'h1FF) $display("FAIL read_buf127: got %h, expected 1ff", host_rdata);
        else n_pass++;
    endtask

    task automatic test_write(input logic [15:0] blk, input bit rnd);
        int cyc;
        logic [31:0] d;
        done_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            d = rnd ? $urandom : 32'(i);
            next_cycle();
            cs = 1'b1; instruction = 32'h8000_0000; disk_addr = {7'(i), 2'b00}; host_wdata = d;
            wr_q.push_back({blk, 7'(i), d});
        end
        next_cycle();
        cs = 1'b0;
        start_pause(1'b1, blk);
        n_total++;
        if ({disk_busy, mem_req} !== 2'b10) $display("FAIL write_load: busy/req=%b, expected 10", {disk_busy, mem_req});
        else n_pass++;
        wait_done(cyc);
        n_total++;
        if (cyc != 257) $display("FAIL write_latency: done at cycle %0d, expected 257", cyc);
        else n_pass++;
        check_queues_and_done("write", 1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        done_cnt = 0;
        cyc = 0;
        push_reads(16'h0002);
        start_pause(1'b0, 16'h0002);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (disk_operate_done) begin
                cyc = c;
                break;
            end
            if (c == 20) begin
                read_pause = 1'b1; write_pause = 1'b1; instruction = 32'h4000_0005;
            end else if (c == 21) begin
                read_pause = 1'b0; write_pause = 1'b0;
            end
            if (c == 50) begin
                cs = 1'b1; instruction = 32'h8000_0000; disk_addr = 9'h000; host_wdata = 32'hCAFE_F00D;
            end else if (c == 51) begin
                cs = 1'b0;
            end
        end
        n_total++;
        if (cyc != 129) $display("FAIL busy_ignore_latency: done at cycle %0d, expected 129", cyc);
        else n_pass++;
        check_queues_and_done("busy_ignore", 1);
        disk_addr = 9'h000;
        #1;
        n_total++;
        if (host_rdata !== 32'h100) $display("FAIL busy_host_write: buf0=%h, expected 100", host_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit found;
        done_cnt = 0;
        found = 1'b0;
        push_reads(16'h0004);
        start_pause(1'b0, 16'h0004);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr[6:0] == 7'd40) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL abort_reach_word40: word 40 not reached, expected within 300 cycles");
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({mem_req, disk_busy} !== 2'b00) $display("FAIL abort_outputs: req/busy=%b, expected 00", {mem_req, disk_busy});
        else n_pass++;
        rd_q.delete();
        repeat (3) @(negedge clk);
        n_total++;
        if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses, expected 0", done_cnt);
        else n_pass++;
        disk_addr = {7'd39, 2'b00};
        #1;
        n_total++;
        if (host_rdata !== 32'h227) $display("FAIL abort_buf39: got %h, expected 227", host_rdata);
        else n_pass++;
        disk_addr = {7'd40, 2'b00};
        #1;
        n_total++;
        if (host_rdata !== 32'h128) $display("FAIL abort_buf40: got %h, expected 128", host_rdata);
        else n_pass++;
        push_reads(16'h0006);
        @(negedge clk);
        rst = 1'b0;
        instruction = 32'h4000_0006;
        read_pause = 1'b1;
        next_cycle();
        read_pause = 1'b0;
        n_total++;
        if ({disk_busy, mem_req} !== 2'b11) $display("FAIL first_edge_accept: busy/req=%b, expected 11", {disk_busy, mem_req});
        else n_pass++;
        wait_done(cyc);
        n_total++;
        if (cyc != 129) $display("FAIL after_abort_latency: done at cycle %0d, expected 129", cyc);
        else n_pass++;
        check_queues_and_done("after_abort", 1);
    endtask

`ifdef DISK_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        done_cnt = 0;
        ack_en = 1'b0;
        rd_q.push_back({16'h0007, 7'd0});
        start_pause(1'b0, 16'h0007);
        wait_done(cyc);
        n_total++;
        if (cyc != TMO + 1) $display("FAIL timeout_latency: done at cycle %0d, expected %0d", cyc, TMO + 1);
        else n_pass++;
        n_total++;
        if ({disk_error, mem_req} !== 2'b10) $display("FAIL timeout_flag: err/req=%b, expected 10", {disk_error, mem_req});
        else n_pass++;
        rd_q.delete();
        ack_en = 1'b1;
        repeat (2) next_cycle();
        n_total++;
        if (disk_error !== 1'b1) $display("FAIL timeout_sticky: err=%b, expected 1", disk_error);
        else n_pass++;
        done_cnt = 0;
        push_reads(16'h0008);
        start_pause(1'b0, 16'h0008);
        n_total++;
        if (disk_error !== 1'b0) $display("FAIL timeout_clear: err=%b, expected 0", disk_error);
        else n_pass++;
        wait_done(cyc);
        n_total++;
        if (cyc != 129) $display("FAIL timeout_recover_latency: done at cycle %0d, expected 129", cyc);
        else n_pass++;
        check_queues_and_done("timeout_recover", 1);
    endtask
`endif

    initial begin
        rst = 1'b1; cs = 1'b0; instruction = 32'd0; write_pause = 1'b0; read_pause = 1'b0;
        disk_addr = 9'd0; host_wdata = 32'd0; ack_en = 1'b1; ack_force = 1'b0;
        test_reset();
        test_host_write();
        test_read();
        test_write(16'h0001, 1'b0);
        test_write(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        test_back_to_back();
        test_reset_abort();
`ifdef DISK_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
